// File: rtl/band_energy_acc_if.sv
// Sample/control/result bundle between the filter-side producer and the band
// energy accumulator. Clock and reset stay as plain module ports.
interface band_energy_acc_if;
  logic        [31:0] sample_in;
  logic               sample_vld;
  logic               en;
  logic               clr;
  logic        [31:0] energy_o;
  logic               energy_vld;
  logic               frame_rst_o;
  logic               drop_o;

  // Producer/controller side: drives samples and control, observes results.
  modport master (
    output sample_in,
    output sample_vld,
    output en,
    output clr,
    input  energy_o,
    input  energy_vld,
    input  frame_rst_o,
    input  drop_o
  );

  // Accumulator side.
  modport slave (
    input  sample_in,
    input  sample_vld,
    input  en,
    input  clr,
    output energy_o,
    output energy_vld,
    output frame_rst_o,
    output drop_o
  );
endinterface

// File: rtl/band_energy_acc.sv
// Frame-based mean-square energy accumulator. Squares the upper half of each
// valid filter sample, sums 2^LOG2_LEN squares per frame and reports the mean
// in a one-cycle DUMP state. Also emits the per-frame filter reload pulse.
module band_energy_acc #(
  parameter int unsigned LOG2_LEN = 8
) (
  input logic             clk_in,
  input logic             rst_sys,
  band_energy_acc_if.slave bus
);

  // A frame of all -32768 samples sums to exactly 2^(30+LOG2_LEN), so one bit
  // beyond 30+LOG2_LEN is needed to hold it without wrapping.
  localparam int unsigned AccW = 31 + LOG2_LEN;
  localparam logic [LOG2_LEN-1:0] CntOne  = LOG2_LEN'(1);
  localparam logic [LOG2_LEN-1:0] CntLast = {LOG2_LEN{1'b1}};

  if (LOG2_LEN < 1 || LOG2_LEN > 12) begin : g_bad_len
    $error("band_energy_acc: LOG2_LEN must be in 1..12");
  end

  typedef enum logic [1:0] {StIdle, StAcc, StDump} state_e;

  state_e              state_q;
  logic [AccW-1:0]     acc_q;
  logic [LOG2_LEN-1:0] cnt_q;
  logic [31:0]         energy_q;
  logic                energy_vld_q;
  logic                frame_rst_q;
  logic                drop_q;

  logic [15:0]         s_raw;
  logic [15:0]         s_mag;
  logic [31:0]         sq;
  logic [AccW-1:0]     acc_sum;
  logic                last_smp;
  logic                unused_sample_lo;

  // Only the upper half of the filter product carries the band signal.
  assign unused_sample_lo = ^bus.sample_in[15:0];
  assign s_raw            = bus.sample_in[31:16];

  // Square via magnitude; |-32768| = 32768 still fits in 16 unsigned bits.
  assign s_mag    = s_raw[15] ? (~s_raw + 16'd1) : s_raw;
  assign sq       = {16'd0, s_mag} * {16'd0, s_mag};
  assign acc_sum  = acc_q + AccW'(sq);
  assign last_smp = (cnt_q == CntLast);

  // Frame sequencing, accumulation and registered outputs.
  always_ff @(posedge clk_in or negedge rst_sys) begin
    if (!rst_sys) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      cnt_q        <= '0;
      energy_q     <= '0;
      energy_vld_q <= 1'b0;
      frame_rst_q  <= 1'b0;
      drop_q       <= 1'b0;
    end else if (bus.clr) begin
      // Abort: no report, no reload pulse, and a coincident sample is ignored.
      state_q      <= StIdle;
      acc_q        <= '0;
      cnt_q        <= '0;
      energy_q     <= '0;
      energy_vld_q <= 1'b0;
      frame_rst_q  <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      energy_vld_q <= 1'b0;
      frame_rst_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.en) begin
            state_q     <= StAcc;
            acc_q       <= '0;
            cnt_q       <= '0;
            frame_rst_q <= 1'b1;
          end
        end
        StAcc: begin
          // en is not consulted here: a started frame always completes.
          if (bus.sample_vld) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + CntOne;
            if (last_smp) begin
              state_q <= StDump;
            end
          end
        end
        StDump: begin
          energy_q     <= {1'b0, acc_q[AccW-1:LOG2_LEN]};
          energy_vld_q <= 1'b1;
          acc_q        <= '0;
          cnt_q        <= '0;
          // The close cycle is the one bubble per frame; a sample here is lost.
          if (bus.sample_vld) begin
            drop_q <= 1'b1;
          end
          if (bus.en) begin
            state_q     <= StAcc;
            frame_rst_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.energy_o    = energy_q;
  assign bus.energy_vld  = energy_vld_q;
  assign bus.frame_rst_o = frame_rst_q;
  assign bus.drop_o      = drop_q;

endmodule

// File: tb/tb_band_energy_acc.sv
// Bench for band_energy_acc at LOG2_LEN=2: directed table, corner sequences
// and random traffic, all checked against a frame-level reference model.
module tb_band_energy_acc;

  localparam int unsigned L = 2;
  localparam int unsigned N = 1 << L;

  logic clk_in;
  logic rst_sys;

  band_energy_acc_if intf ();

  band_energy_acc #(.LOG2_LEN(L)) u_dut (
    .clk_in  (clk_in),
    .rst_sys (rst_sys),
    .bus     (intf)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_vec;
  int n_err;

  // Reference model: squares of the current frame's accepted samples.
  longint      m_q[$];
  bit          m_run;
  bit          m_close;
  logic [31:0] m_energy;
  bit          m_vld;
  bit          m_frst;
  bit          m_drop;

  task automatic model_reset();
    m_q.delete();
    m_run    = 0;
    m_close  = 0;
    m_energy = '0;
    m_vld    = 0;
    m_frst   = 0;
    m_drop   = 0;
  endtask

  task automatic model_edge(input bit en, input bit clr, input bit vld,
                            input logic [31:0] smp);
    longint sum;
    longint s;
    m_vld  = 0;
    m_frst = 0;
    if (clr) begin
      model_reset();
    end else if (m_close) begin
      sum = 0;
      foreach (m_q[i]) sum += m_q[i];
      m_energy = 32'(sum / N);
      m_vld    = 1;
      if (vld) m_drop = 1;
      m_close = 0;
      m_q.delete();
      m_run  = en;
      m_frst = en;
    end else if (m_run) begin
      if (vld) begin
        s = longint'($signed(smp[31:16]));
        m_q.push_back(s * s);
        if (m_q.size() == N) m_close = 1;
      end
    end else if (en) begin
      m_run  = 1;
      m_frst = 1;
      m_q.delete();
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input bit en, input bit clr, input bit vld, input logic [31:0] smp);
    intf.en         = en;
    intf.clr        = clr;
    intf.sample_vld = vld;
    intf.sample_in  = smp;
    @(posedge clk_in);
    model_edge(en, clr, vld, smp);
    #1;
    check("energy_o",    intf.energy_o,           m_energy);
    check("energy_vld",  32'(intf.energy_vld),    32'(m_vld));
    check("frame_rst_o", 32'(intf.frame_rst_o),   32'(m_frst));
    check("drop_o",      32'(intf.drop_o),        32'(m_drop));
  endtask

  function automatic logic [31:0] smp_of(input int s);
    logic [15:0] h;
    h = 16'(s);
    return {h, 16'h0000};
  endfunction

  typedef struct {
    bit          en;
    bit          vld;
    logic [31:0] smp;
    logic [31:0] e_energy;
    bit          e_vld;
    bit          e_frst;
    bit          e_drop;
  } vec_t;

  vec_t tbl[12];

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();

    // Directed frames: 4 x s=256, then 4 x s=-32768 with en already low.
    tbl[0]  = '{1, 0, 32'h0000_0000, 32'd0,        0, 1, 0};
    tbl[1]  = '{1, 1, 32'h0100_0000, 32'd0,        0, 0, 0};
    tbl[2]  = '{1, 1, 32'h0100_0000, 32'd0,        0, 0, 0};
    tbl[3]  = '{1, 1, 32'h0100_0000, 32'd0,        0, 0, 0};
    tbl[4]  = '{1, 1, 32'h0100_0000, 32'd0,        0, 0, 0};
    tbl[5]  = '{1, 0, 32'h0000_0000, 32'd65536,    1, 1, 0};
    tbl[6]  = '{0, 0, 32'h0000_0000, 32'd65536,    0, 0, 0};
    tbl[7]  = '{0, 1, 32'h8000_0000, 32'd65536,    0, 0, 0};
    tbl[8]  = '{0, 1, 32'h8000_0000, 32'd65536,    0, 0, 0};
    tbl[9]  = '{0, 1, 32'h8000_0000, 32'd65536,    0, 0, 0};
    tbl[10] = '{0, 1, 32'h8000_0000, 32'd65536,    0, 0, 0};
    tbl[11] = '{0, 0, 32'h0000_0000, 32'h4000_0000, 1, 0, 0};

    intf.en = 0; intf.clr = 0; intf.sample_vld = 0; intf.sample_in = '0;
    rst_sys = 0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst energy_o", intf.energy_o, 32'd0);
    check("rst flags", {29'd0, intf.energy_vld, intf.frame_rst_o, intf.drop_o}, 32'd0);
    @(negedge clk_in);
    rst_sys = 1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, 1'b0, tbl[i].vld, tbl[i].smp);
      check($sformatf("tbl[%0d] energy_o", i), intf.energy_o, tbl[i].e_energy);
      check($sformatf("tbl[%0d] flags", i),
            {29'd0, intf.energy_vld, intf.frame_rst_o, intf.drop_o},
            {29'd0, tbl[i].e_vld, tbl[i].e_frst, tbl[i].e_drop});
    end

    // Gapped samples 1..4 with 0..3 idle cycles; sample in DUMP is dropped.
    step(1, 0, 0, '0);
    for (int s = 1; s <= 4; s++) begin
      for (int g = 0; g < s - 1; g++) step(1, 0, 0, smp_of(99));
      step(1, 0, 1, smp_of(s));
    end
    step(1, 0, 1, smp_of(100));
    check("gap energy_o", intf.energy_o, 32'd7);
    check("gap drop_o", 32'(intf.drop_o), 32'd1);
    check("b2b frame_rst_o", 32'(intf.frame_rst_o), 32'd1);
    for (int k = 0; k < 4; k++) step(1, 0, 1, smp_of(2));
    step(0, 0, 0, '0);
    check("post-drop energy_o", intf.energy_o, 32'd4);
    check("drop sticky", 32'(intf.drop_o), 32'd1);
    step(0, 1, 1, smp_of(5));
    check("clr drop_o", 32'(intf.drop_o), 32'd0);
    check("clr energy_o", intf.energy_o, 32'd0);

    // en falls after sample 2: frame still closes, then stays idle.
    step(1, 0, 0, '0);
    step(1, 0, 1, smp_of(3));
    step(1, 0, 1, smp_of(3));
    step(0, 0, 1, smp_of(3));
    step(0, 0, 1, smp_of(3));
    step(0, 0, 0, '0);
    check("en-drop energy_o", intf.energy_o, 32'd9);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, k[0], smp_of(7));
      check("idle frame_rst_o", 32'(intf.frame_rst_o), 32'd0);
    end
    step(1, 0, 0, '0);
    check("re-en frame_rst_o", 32'(intf.frame_rst_o), 32'd1);

    // Asynchronous reset after sample 3 of a frame.
    for (int k = 0; k < 3; k++) step(1, 0, 1, smp_of(5));
    #2 rst_sys = 0;
    #1;
    check("async energy_o", intf.energy_o, 32'd0);
    check("async flags", {29'd0, intf.energy_vld, intf.frame_rst_o, intf.drop_o}, 32'd0);
    model_reset();
    #2 rst_sys = 1;
    step(1, 0, 0, '0);
    for (int k = 0; k < 4; k++) step(1, 0, 1, smp_of(6));
    step(0, 0, 0, '0);
    check("post-reset energy_o", intf.energy_o, 32'd36);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 7) == 0) r[31:16] = 16'h8000;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 9) < 7, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
